// File: rtl/gin_pkg.sv
// Shared definitions for the GIN multicast block: parameter defaults,
// delivery FSM states and the queued entry layout.
package gin_pkg;

   localparam int GIN_DATA_W     = 32;
   localparam int GIN_ROWS       = 6;
   localparam int GIN_COLS       = 8;
   localparam int GIN_XID_W      = 5;
   localparam int GIN_YID_W      = 3;
   localparam int GIN_FIFO_DEPTH = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } gin_state_e;

   // Queue entry as stored, tags above payload
   typedef struct packed {
      logic [GIN_YID_W-1:0] tag_y;
      logic [GIN_XID_W-1:0] tag_x;
      logic [GIN_DATA_W-1:0] data;
   } gin_entry_t;

endpackage

// File: rtl/gin_fifo.sv
// Synchronous input queue with registered count and full/empty flags; also
// exposes the upper NW bits of the entry behind the head for lookahead.
module gin_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4,
   parameter int NW    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [W-1:0]           i_wdata,
   input  logic                   i_pop,
   output logic [W-1:0]           o_head,
   output logic [NW-1:0]          o_next_tag,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [AW-1:0] w_next_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count define
   // which slots are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign w_next_ptr = r_rd_ptr + AW'(1);
   assign o_head     = r_mem[r_rd_ptr];
   assign o_next_tag = r_mem[w_next_ptr][W-1 -: NW];
   assign o_count    = r_count;
   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_empty    = (r_count == '0);

endmodule

// File: rtl/gin_multicast.sv
// GIN multicast: queues tagged payloads and delivers each to every PE whose
// scanned row/col IDs match. Optional drop counter: define GIN_DROP_CNT_EN.
module gin_multicast
   import gin_pkg::*;
#(
   parameter int DATA_W     = GIN_DATA_W,
   parameter int ROWS       = GIN_ROWS,
   parameter int COLS       = GIN_COLS,
   parameter int XID_W      = GIN_XID_W,
   parameter int YID_W      = GIN_YID_W,
   parameter int FIFO_DEPTH = GIN_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   gin_valid,
   output logic                   gin_ready,
   input  logic [DATA_W-1:0]      gin_data,
   input  logic [XID_W-1:0]       tag_x,
   input  logic [YID_W-1:0]       tag_y,
   input  logic                   set_xid,
   input  logic [XID_W-1:0]       xid_scan_in,
   output logic [XID_W-1:0]       xid_scan_out,
   input  logic                   set_yid,
   input  logic [YID_W-1:0]       yid_scan_in,
   output logic [YID_W-1:0]       yid_scan_out,
   input  logic [ROWS*COLS-1:0]   pe_ready,
   output logic [ROWS*COLS-1:0]   pe_valid,
   output logic [DATA_W-1:0]      pe_data,
   output logic                   busy,
   output logic                   dropped
`ifdef GIN_DROP_CNT_EN
   ,output logic [15:0]           drop_cnt
`endif
);

   localparam int NPE     = ROWS * COLS;
   localparam int TAG_W   = YID_W + XID_W;
   localparam int ENTRY_W = TAG_W + DATA_W;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   logic [YID_W-1:0] r_row_id [ROWS];
   logic [XID_W-1:0] r_col_id [NPE];
   gin_state_e       r_state, w_state_nxt;
   logic [NPE-1:0]   r_pending, w_pending_nxt, w_remaining;
   logic [NPE-1:0]   w_head_mask, w_next_mask;

   logic [ENTRY_W-1:0] w_head;
   logic [TAG_W-1:0]   w_next_tag;
   logic [CNT_W-1:0]   w_count;
   logic               w_full, w_empty, w_push, w_pop;
   logic [DATA_W-1:0]  w_head_data;
   logic [XID_W-1:0]   w_head_x, w_next_x;
   logic [YID_W-1:0]   w_head_y, w_next_y;

   assign w_push = gin_valid && !w_full;

   gin_fifo #(
      .W     (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .NW    (TAG_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_wdata    ({tag_y, tag_x, gin_data}),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_next_tag (w_next_tag),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign w_head_data = w_head[DATA_W-1:0];
   assign w_head_x    = w_head[DATA_W +: XID_W];
   assign w_head_y    = w_head[DATA_W+XID_W +: YID_W];
   assign w_next_x    = w_next_tag[XID_W-1:0];
   assign w_next_y    = w_next_tag[TAG_W-1 -: YID_W];

   // An all-ones row or column ID takes the PE out of every match
   always_comb begin
      w_head_mask = '0;
      w_next_mask = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if ((r_row_id[r] != '1) && (r_col_id[r*COLS+c] != '1)) begin
               w_head_mask[r*COLS+c] = (r_row_id[r] == w_head_y) && (r_col_id[r*COLS+c] == w_head_x);
               w_next_mask[r*COLS+c] = (r_row_id[r] == w_next_y) && (r_col_id[r*COLS+c] == w_next_x);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < ROWS; r++) r_row_id[r] <= '1;
         for (int i = 0; i < NPE; i++)  r_col_id[i] <= '1;
      end else begin
         if (set_yid && !busy) begin
            r_row_id[0] <= yid_scan_in;
            for (int r = 1; r < ROWS; r++) r_row_id[r] <= r_row_id[r-1];
         end
         if (set_xid && !busy) begin
            r_col_id[0] <= xid_scan_in;
            for (int i = 1; i < NPE; i++) r_col_id[i] <= r_col_id[i-1];
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_pop         = 1'b0;
      w_remaining   = r_pending & ~pe_ready;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_state_nxt   = ST_SEND;
               w_pending_nxt = w_head_mask;
            end
         end
         ST_SEND: begin
            if (w_remaining == '0) begin
               w_pop = 1'b1;
               // A lone entry always returns to IDLE, even with a same-cycle push
               if (w_count >= CNT_W'(2)) begin
                  w_pending_nxt = w_next_mask;
               end else begin
                  w_state_nxt   = ST_IDLE;
                  w_pending_nxt = '0;
               end
            end else begin
               w_pending_nxt = w_remaining;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   assign gin_ready    = !w_full;
   assign pe_valid     = (r_state == ST_SEND) ? r_pending : '0;
   assign pe_data      = (r_state == ST_SEND) ? w_head_data : '0;
   assign busy         = !w_empty || (r_state == ST_SEND);
   assign dropped      = (r_state == ST_SEND) && (r_pending == '0);
   assign xid_scan_out = r_col_id[NPE-1];
   assign yid_scan_out = r_row_id[ROWS-1];

`ifdef GIN_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_drop_cnt <= '0;
      end else if (dropped && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_gin_multicast.sv
// Directed bench for gin_multicast: stimulus queues expected deliveries,
// a negedge monitor pops and compares each entry the DUT presents.
module tb_gin_multicast;
   import gin_pkg::*;

   localparam int NPE = GIN_ROWS * GIN_COLS;
   localparam logic [NPE-1:0] ONE = 1;

   typedef struct packed {
      logic                  drop;
      logic [NPE-1:0]        mask;
      logic [GIN_DATA_W-1:0] data;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  gin_valid, gin_ready;
   logic [GIN_DATA_W-1:0] gin_data;
   logic [GIN_XID_W-1:0]  tag_x, xid_scan_in, xid_scan_out;
   logic [GIN_YID_W-1:0]  tag_y, yid_scan_in, yid_scan_out;
   logic                  set_xid, set_yid;
   logic [NPE-1:0]        pe_ready, pe_valid;
   logic [GIN_DATA_W-1:0] pe_data;
   logic                  busy, dropped;
`ifdef GIN_DROP_CNT_EN
   logic [15:0]           drop_cnt;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   gin_multicast dut (
      .clk          (clk),
      .rst          (rst),
      .gin_valid    (gin_valid),
      .gin_ready    (gin_ready),
      .gin_data     (gin_data),
      .tag_x        (tag_x),
      .tag_y        (tag_y),
      .set_xid      (set_xid),
      .xid_scan_in  (xid_scan_in),
      .xid_scan_out (xid_scan_out),
      .set_yid      (set_yid),
      .yid_scan_in  (yid_scan_in),
      .yid_scan_out (yid_scan_out),
      .pe_ready     (pe_ready),
      .pe_valid     (pe_valid),
      .pe_data      (pe_data),
      .busy         (busy),
      .dropped      (dropped)
`ifdef GIN_DROP_CNT_EN
      ,.drop_cnt    (drop_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [GIN_YID_W-1:0] y, input logic [GIN_XID_W-1:0] x,
                       input logic [GIN_DATA_W-1:0] d, input logic [NPE-1:0] mask,
                       input logic drop);
      gin_entry_t e;
      exp_t       ex;
      e = '{tag_y: y, tag_x: x, data: d};
      gin_valid = 1'b1;
      tag_y     = e.tag_y;
      tag_x     = e.tag_x;
      gin_data  = e.data;
      check("push_ready", gin_ready, 1'b1);
      ex.drop = drop;
      ex.mask = mask;
      ex.data = e.data;
      exp_q.push_back(ex);
      step();
      gin_valid = 1'b0;
   endtask

   // fixed < 0 loads col_id[i] = i % COLS, otherwise every column gets fixed
   task automatic scan_cols(input int fixed);
      for (int i = NPE - 1; i >= 0; i--) begin
         set_xid     = 1'b1;
         xid_scan_in = (fixed < 0) ? GIN_XID_W'(i % GIN_COLS) : GIN_XID_W'(fixed);
         step();
      end
      set_xid = 1'b0;
   endtask

   task automatic scan_rows();
      for (int r = GIN_ROWS - 1; r >= 0; r--) begin
         set_yid     = 1'b1;
         yid_scan_in = GIN_YID_W'(r);
         step();
      end
      set_yid = 1'b0;
   endtask

   // Scoreboard monitor: samples mid-cycle, one expected item per entry
   initial begin : monitor
      logic                  in_entry;
      logic [NPE-1:0]        want_vld;
      logic [GIN_DATA_W-1:0] held;
      exp_t                  e;
      in_entry = 1'b0;
      want_vld = '0;
      held     = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            in_entry = 1'b0;
         end else if (dropped) begin
            if (exp_q.size() == 0) begin
               check("unexpected_drop", dropped, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("drop_expected", e.drop, 1'b1);
               check("drop_pe_valid", pe_valid, '0);
            end
         end else if (pe_valid != '0) begin
            if (!in_entry) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", pe_valid, '0);
               end else begin
                  e = exp_q.pop_front();
                  check("entry_not_drop", e.drop, 1'b0);
                  check("entry_mask", pe_valid, e.mask);
                  check("entry_data", pe_data, e.data);
                  in_entry = 1'b1;
                  held     = pe_data;
               end
            end else begin
               check("valid_shrink", pe_valid, want_vld);
               check("data_hold", pe_data, held);
            end
            if (in_entry) begin
               want_vld = pe_valid & ~pe_ready;
               if (want_vld == '0) in_entry = 1'b0;
            end
         end else if (in_entry) begin
            check("valid_lost", pe_valid, want_vld);
            in_entry = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst         = 1'b0;
      gin_valid   = 1'b0;
      gin_data    = '0;
      tag_x       = '0;
      tag_y       = '0;
      set_xid     = 1'b0;
      set_yid     = 1'b0;
      xid_scan_in = '0;
      yid_scan_in = '0;
      pe_ready    = '1;
      step();
      step();

      check("rst_gin_ready", gin_ready, 1'b1);
      check("rst_pe_valid", pe_valid, '0);
      check("rst_pe_data", pe_data, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_dropped", dropped, 1'b0);
      check("rst_xid_out", xid_scan_out, 5'h1F);
      check("rst_yid_out", yid_scan_out, 3'h7);
`ifdef GIN_DROP_CNT_EN
      check("rst_drop_cnt", drop_cnt, 16'd0);
`endif
      rst = 1'b1;
      step();

      // Tag matching only disabled (all-ones) IDs is discarded
      push(3'd7, 5'd31, 32'hDEAD_BEEF, '0, 1'b1);
      check("drop_idle_pe_valid", pe_valid, '0);
      step();
      check("drop_pulse", dropped, 1'b1);
      check("drop_pe_valid", pe_valid, '0);
      step();
      check("drop_pulse_end", dropped, 1'b0);
      check("drop_busy_end", busy, 1'b0);
`ifdef GIN_DROP_CNT_EN
      check("drop_cnt_one", drop_cnt, 16'd1);
`endif

      scan_rows();
      scan_cols(-1);
      check("scan_yid_out", yid_scan_out, 3'd5);
      check("scan_xid_out", xid_scan_out, 5'd7);

      // Unicast to PE (row 2, col 5) = bit 21, two-cycle latency, one cycle wide
      pe_ready = '1;
      push(3'd2, 5'd5, 32'hA5A5_A5A5, ONE << 21, 1'b0);
      check("uni_t1_pe_valid", pe_valid, '0);
      check("uni_t1_busy", busy, 1'b1);
      step();
      check("uni_t2_pe_valid", pe_valid, ONE << 21);
      check("uni_t2_pe_data", pe_data, 32'hA5A5_A5A5);
      step();
      check("uni_done_pe_valid", pe_valid, '0);
      check("uni_done_busy", busy, 1'b0);

      // Scan pulses while busy must not move either chain
      pe_ready = '0;
      push(3'd0, 5'd0, 32'h0000_1111, ONE, 1'b0);
      step();
      check("busy_hold_busy", busy, 1'b1);
      set_xid     = 1'b1;
      xid_scan_in = 5'd9;
      set_yid     = 1'b1;
      yid_scan_in = 3'd2;
      step();
      set_xid  = 1'b0;
      set_yid  = 1'b0;
      check("busy_xid_out", xid_scan_out, 5'd7);
      check("busy_yid_out", yid_scan_out, 3'd5);
      pe_ready = '1;
      step();
      check("busy_done", busy, 1'b0);
      push(3'd0, 5'd0, 32'h2222_0000, ONE, 1'b0);
      step();
      step();
      check("busy_reroute_done", busy, 1'b0);

      // Multicast to row 1 with staggered acceptance
      scan_cols(3);
      check("mc_xid_out", xid_scan_out, 5'd3);
      pe_ready = '0;
      push(3'd1, 5'd3, 32'h1234_5678, 48'h0000_0000_FF00, 1'b0);
      step();
      check("mc_c1_pe_valid", pe_valid, 48'h0000_0000_FF00);
      pe_ready = 48'h0000_0000_0F00;
      step();
      check("mc_c2_pe_valid", pe_valid, 48'h0000_0000_F000);
      check("mc_c2_pe_data", pe_data, 32'h1234_5678);
      pe_ready = '0;
      step();
      check("mc_c3_pe_valid", pe_valid, 48'h0000_0000_F000);
      check("mc_c3_busy", busy, 1'b1);
      pe_ready = 48'h0000_0000_F000;
      step();
      check("mc_pop_pe_valid", pe_valid, '0);
      check("mc_pop_busy", busy, 1'b0);

      // Fill the queue with every PE stalled, then drain back to back
      pe_ready = '0;
      for (int k = 0; k < 4; k++) begin
         push(GIN_YID_W'(k), 5'd3, 32'hC0DE_0000 + 32'(k), 48'hFF << (8 * k), 1'b0);
      end
      check("fill_not_ready", gin_ready, 1'b0);
      step();
      check("fill_still_full", gin_ready, 1'b0);
      check("fill_head_valid", pe_valid, 48'h0000_0000_00FF);
      pe_ready = '1;
      step();
      check("drain_1", pe_valid, 48'h0000_0000_FF00);
      check("drain_1_ready", gin_ready, 1'b1);
      step();
      check("drain_2", pe_valid, 48'h0000_00FF_0000);
      step();
      check("drain_3", pe_valid, 48'h0000_FF00_0000);
      check("drain_3_data", pe_data, 32'hC0DE_0003);
      step();
      check("drain_done_pe_valid", pe_valid, '0);
      check("drain_done_busy", busy, 1'b0);

      // Reset in the middle of a delivery
      pe_ready = '0;
      push(3'd4, 5'd3, 32'hBAD0_0000, 48'h00FF_0000_0000, 1'b0);
      step();
      check("mid_pe_valid", pe_valid, 48'h00FF_0000_0000);
      exp_q.delete();
      rst = 1'b0;
      step();
      check("mid_rst_pe_valid", pe_valid, '0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_xid_out", xid_scan_out, 5'h1F);
      check("mid_rst_yid_out", yid_scan_out, 3'h7);
      check("mid_rst_gin_ready", gin_ready, 1'b1);
`ifdef GIN_DROP_CNT_EN
      check("mid_rst_drop_cnt", drop_cnt, 16'd0);
`endif
      rst = 1'b1;
      step();
      step();
      check("idle_after_rst", busy, 1'b0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
